// File: rtl/hex_scan_pkg.sv
// Shared types and constants for the 4-digit hex display scanner.
// Used by hex_scan_timer and hex_scan_ctrl.
package hex_scan_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int NIBBLE_W   = 4;
   localparam int VALUE_W    = NUM_DIGITS * NIBBLE_W;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } state_e;

   typedef logic [1:0] digit_idx_t;

   function automatic logic [NIBBLE_W-1:0] nibble_at(input logic [VALUE_W-1:0] value,
                                                     input digit_idx_t         idx);
      return value[{idx, 2'b00} +: NIBBLE_W];
   endfunction

   function automatic logic [NUM_DIGITS-1:0] digit_onehot(input digit_idx_t idx);
      return NUM_DIGITS'(1) << idx;
   endfunction

endpackage

// File: rtl/hex_scan_timer.sv
// Phase timer: down-counter from zero that strobes done on the enabled clock
// where it reaches -term, then restarts at zero (so a phase lasts term+1 clocks).
module hex_scan_timer
   import hex_scan_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] term,
   output logic         done
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;
   logic [W-1:0] end_val;
   logic         at_end;

   // Counting down from zero keeps the reset value at zero while the phase
   // length still comes entirely from term.
   always_comb begin
      end_val = ~term + 1'b1;
      at_end  = (cnt_q == end_val);
      done    = en && at_end;
      cnt_d   = cnt_q;
      if (en) begin
         cnt_d = at_end ? '0 : cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/hex_scan_ctrl.sv
// 4-digit hex scan controller: BLANK/SHOW scheduler, write port and 16-bit counter.
// Define HEX_SCAN_LZ_BLANK_EN to suppress leading-zero digits during SHOW.
module hex_scan_ctrl
   import hex_scan_pkg::*;
#(
   parameter int PRESCALE_W  = 8,
   parameter int DEAD_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ena,
   input  logic                  wr_valid,
   input  logic [1:0]            wr_idx,
   input  logic [NIBBLE_W-1:0]   wr_data,
   output logic                  wr_ready,
   input  logic                  cnt_en,
   input  logic                  cnt_tick,
   output logic                  cnt_wrap,
   output logic [NIBBLE_W-1:0]   seg_nibble,
   output logic [NUM_DIGITS-1:0] digit_en,
   output logic                  blank,
   output logic                  frame_start
);

   localparam int TW = (PRESCALE_W > 4) ? PRESCALE_W : 4;
   localparam logic [TW-1:0] DEAD_TERM = TW'(DEAD_CYCLES - 1);
   localparam logic [TW-1:0] SHOW_TERM = TW'((64'd1 << PRESCALE_W) - 64'd1);

   state_e                  state_q, state_d;
   digit_idx_t              idx_q, idx_d;
   logic [VALUE_W-1:0]      digits_q, digits_d;
   logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
   logic [NIBBLE_W-1:0]     seg_nibble_q, seg_nibble_d;
   logic                    blank_q, blank_d;
   logic                    frame_start_q, frame_start_d;
   logic                    cnt_wrap_q, cnt_wrap_d;
   logic                    phase_done;
   logic [TW-1:0]           phase_term;
   logic                    show_en;

   assign phase_term = (state_q == BLANK) ? DEAD_TERM : SHOW_TERM;

   hex_scan_timer #(
      .W (TW)
   ) u_timer (
      .clk  (clk),
      .rst  (rst),
      .en   (ena),
      .term (phase_term),
      .done (phase_done)
   );

   assign wr_ready = !cnt_en;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_d       = state_q;
      idx_d         = idx_q;
      digits_d      = digits_q;
      cnt_wrap_d    = 1'b0;
      digit_en_d    = digit_en_q;
      seg_nibble_d  = seg_nibble_q;
      blank_d       = blank_q;
      frame_start_d = 1'b0;
      show_en       = 1'b1;

      if (ena && phase_done) begin
         case (state_q)
            BLANK: state_d = SHOW;
            SHOW: begin
               state_d = BLANK;
               idx_d   = idx_q + 2'd1;
            end
            default: state_d = BLANK;
         endcase
      end

      // cnt_en selects the single owner of the digit registers.
      if (cnt_en) begin
         if (cnt_tick) begin
            digits_d   = digits_q + 1'b1;
            cnt_wrap_d = &digits_q;
         end
      end else if (wr_valid) begin
         digits_d[{wr_idx, 2'b00} +: NIBBLE_W] = wr_data;
      end

`ifdef HEX_SCAN_LZ_BLANK_EN
      if ((idx_d != 2'd0) && ((digits_d >> {idx_d, 2'b00}) == '0)) begin
         show_en = 1'b0;
      end
`endif

      // Outputs follow next-state values so they are registered yet aligned with state.
      if (ena) begin
         blank_d       = (state_d == BLANK);
         digit_en_d    = (state_d == SHOW && show_en) ? digit_onehot(idx_d) : '0;
         seg_nibble_d  = (state_d == SHOW) ? nibble_at(digits_d, idx_d) : '0;
         frame_start_d = phase_done && (state_q == BLANK) && (idx_q == 2'd0);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= BLANK;
         idx_q         <= '0;
         digits_q      <= '0;
         digit_en_q    <= '0;
         seg_nibble_q  <= '0;
         blank_q       <= 1'b1;
         frame_start_q <= 1'b0;
         cnt_wrap_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         digits_q      <= digits_d;
         digit_en_q    <= digit_en_d;
         seg_nibble_q  <= seg_nibble_d;
         blank_q       <= blank_d;
         frame_start_q <= frame_start_d;
         cnt_wrap_q    <= cnt_wrap_d;
      end
   end

   assign digit_en    = digit_en_q;
   assign seg_nibble  = seg_nibble_q;
   assign blank       = blank_q;
   assign frame_start = frame_start_q;
   assign cnt_wrap    = cnt_wrap_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Self-checking bench for hex_scan_ctrl (PRESCALE_W=2, DEAD_CYCLES=2) against a
// position/value reference model; honours HEX_SCAN_LZ_BLANK_EN when defined.
module tb_hex_scan_ctrl;

   localparam int PW       = 2;
   localparam int DC       = 2;
   localparam int SHOW_LEN = 1 << PW;
   localparam int SLOT     = DC + SHOW_LEN;
   localparam int PERIOD   = 4 * SLOT;

   logic       clk;
   logic       rst;
   logic       ena;
   logic       wr_valid;
   logic [1:0] wr_idx;
   logic [3:0] wr_data;
   logic       wr_ready;
   logic       cnt_en;
   logic       cnt_tick;
   logic       cnt_wrap;
   logic [3:0] seg_nibble;
   logic [3:0] digit_en;
   logic       blank;
   logic       frame_start;

   int errors = 0;
   int checks = 0;

   // Reference model: enabled clocks since reset plus the 16-bit display value.
   int unsigned kpos;
   int unsigned val;
   logic [3:0]  exp_en;
   logic [3:0]  exp_seg;
   logic        exp_blank;
   logic        exp_fs;
   logic        exp_wrap;
   int unsigned ncycle;

   hex_scan_ctrl #(
      .PRESCALE_W  (PW),
      .DEAD_CYCLES (DC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ena         (ena),
      .wr_valid    (wr_valid),
      .wr_idx      (wr_idx),
      .wr_data     (wr_data),
      .wr_ready    (wr_ready),
      .cnt_en      (cnt_en),
      .cnt_tick    (cnt_tick),
      .cnt_wrap    (cnt_wrap),
      .seg_nibble  (seg_nibble),
      .digit_en    (digit_en),
      .blank       (blank),
      .frame_start (frame_start)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic bit model_lz_hidden(int unsigned d, int unsigned v);
`ifdef HEX_SCAN_LZ_BLANK_EN
      return (d != 0) && ((v >> (4 * d)) == 0);
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      kpos      = 0;
      val       = 0;
      exp_en    = 4'b0000;
      exp_seg   = 4'h0;
      exp_blank = 1'b1;
      exp_fs    = 1'b0;
      exp_wrap  = 1'b0;
   endtask

   // Advance one clock and move the model by the same edge, then settle 1 time unit.
   task automatic tick();
      int unsigned r;
      int unsigned d;
      @(posedge clk);
      ncycle++;
      exp_wrap = 1'b0;
      if (cnt_en) begin
         if (cnt_tick) begin
            if (val == 32'hFFFF) begin
               val      = 0;
               exp_wrap = 1'b1;
            end else begin
               val = val + 1;
            end
         end
      end else if (wr_valid) begin
         val = (val & ~(32'hF << (4 * wr_idx))) | (32'(wr_data) << (4 * wr_idx));
      end
      exp_fs = 1'b0;
      if (ena) begin
         kpos++;
         r         = kpos % SLOT;
         d         = (kpos % PERIOD) / SLOT;
         exp_blank = (r < DC);
         exp_seg   = exp_blank ? 4'h0 : 4'((val >> (4 * d)) & 32'hF);
         exp_en    = (exp_blank || model_lz_hidden(d, val)) ? 4'b0000 : 4'(1 << d);
         exp_fs    = (r == DC) && (d == 0);
      end
      #1;
   endtask

   task automatic idle_inputs();
      wr_valid = 1'b0;
      wr_idx   = 2'd0;
      wr_data  = 4'h0;
      cnt_tick = 1'b0;
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      ena    = 1'b0;
      cnt_en = 1'b0;
      idle_inputs();
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      checks++;
      if ({digit_en, blank, seg_nibble, frame_start, cnt_wrap} !== {exp_en, exp_blank, exp_seg, exp_fs, exp_wrap}) begin
         errors++;
         $display("FAIL reset_outputs: got en=%b blank=%b seg=%h fs=%b wrap=%b, want en=%b blank=%b seg=%h fs=%b wrap=%b",
                  digit_en, blank, seg_nibble, frame_start, cnt_wrap, exp_en, exp_blank, exp_seg, exp_fs, exp_wrap);
      end
      checks++;
      if (wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_wr_ready: got %b want 1", wr_ready);
      end
      rst = 1'b0;
   endtask

   task automatic test_scan_timing();
      int last_fs = -1;
      ena = 1'b1;
      for (int i = 0; i < 2 * PERIOD + 3; i++) begin
         tick();
         checks++;
         if ({digit_en, blank, seg_nibble, frame_start} !== {exp_en, exp_blank, exp_seg, exp_fs}) begin
            errors++;
            $display("FAIL scan_timing[%0d]: got en=%b blank=%b seg=%h fs=%b, want en=%b blank=%b seg=%h fs=%b",
                     i, digit_en, blank, seg_nibble, frame_start, exp_en, exp_blank, exp_seg, exp_fs);
         end
         if (frame_start === 1'b1) begin
            if (last_fs >= 0) begin
               checks++;
               if (i - last_fs != PERIOD) begin
                  errors++;
                  $display("FAIL frame_period: got %0d clocks want %0d", i - last_fs, PERIOD);
               end
            end
            last_fs = i;
         end
      end
   endtask

   task automatic test_write();
      bit seen = 1'b0;
      cnt_en = 1'b0;
      for (int i = 0; i < 40; i++) begin
         wr_valid = 1'($urandom_range(0, 1));
         wr_idx   = 2'($urandom_range(0, 3));
         wr_data  = 4'($urandom_range(0, 15));
         tick();
         checks++;
         if ({digit_en, blank, seg_nibble, frame_start} !== {exp_en, exp_blank, exp_seg, exp_fs}) begin
            errors++;
            $display("FAIL rand_write[%0d]: got en=%b seg=%h blank=%b fs=%b, want en=%b seg=%h blank=%b fs=%b",
                     i, digit_en, seg_nibble, blank, frame_start, exp_en, exp_seg, exp_blank, exp_fs);
         end
      end
      wr_valid = 1'b1;
      wr_idx   = 2'd2;
      wr_data  = 4'hA;
      tick();
      idle_inputs();
      for (int i = 0; i < PERIOD + SLOT && !seen; i++) begin
         tick();
         if (!exp_blank && ((kpos % PERIOD) / SLOT) == 2) begin
            seen = 1'b1;
            checks++;
            if (seg_nibble !== 4'hA || digit_en !== 4'b0100) begin
               errors++;
               $display("FAIL write_idx2_show: got seg=%h en=%b want seg=a en=0100", seg_nibble, digit_en);
            end
         end
      end
      if (!seen) begin
         errors++;
         checks++;
         $display("FAIL write_idx2_timeout: digit 2 SHOW not reached");
      end
   endtask

   task automatic test_counter();
      int wraps = 0;
      cnt_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1'b1;
         wr_idx   = 2'(i);
         wr_data  = (i == 0) ? 4'hE : 4'hF;
         tick();
      end
      idle_inputs();
      cnt_en   = 1'b1;
      cnt_tick = 1'b1;
      wr_valid = 1'b1;
      wr_idx   = 2'd1;
      wr_data  = 4'h3;
      #1;
      checks++;
      if (wr_ready !== 1'b0) begin
         errors++;
         $display("FAIL wr_ready_blocked: got %b want 0", wr_ready);
      end
      for (int i = 0; i < 5; i++) begin
         if (i == 2) cnt_tick = 1'b0;
         tick();
         if (cnt_wrap === 1'b1) wraps++;
         checks++;
         if ({cnt_wrap, seg_nibble, digit_en} !== {exp_wrap, exp_seg, exp_en}) begin
            errors++;
            $display("FAIL counter_wrap[%0d]: got wrap=%b seg=%h en=%b, want wrap=%b seg=%h en=%b",
                     i, cnt_wrap, seg_nibble, digit_en, exp_wrap, exp_seg, exp_en);
         end
      end
      checks++;
      if (wraps != 1 || val != 0) begin
         errors++;
         $display("FAIL wrap_count: got %0d pulses (model value %h) want 1 pulse, value 0000", wraps, val);
      end
      for (int i = 0; i < PERIOD; i++) begin
         tick();
         checks++;
         if ({seg_nibble, digit_en, cnt_wrap} !== {exp_seg, exp_en, exp_wrap}) begin
            errors++;
            $display("FAIL counter_hold[%0d]: got seg=%h en=%b wrap=%b want seg=%h en=%b wrap=%b",
                     i, seg_nibble, digit_en, cnt_wrap, exp_seg, exp_en, exp_wrap);
         end
      end
      idle_inputs();
   endtask

   task automatic test_freeze();
      bit found = 1'b0;
      cnt_en = 1'b0;
      for (int i = 0; i < PERIOD + SLOT && !found; i++) begin
         tick();
         if (((kpos % PERIOD) / SLOT) == 1 && (kpos % SLOT) == DC + 1) found = 1'b1;
      end
      if (!found) begin
         errors++;
         checks++;
         $display("FAIL freeze_timeout: mid-SHOW of digit 1 not reached");
      end
      ena = 1'b0;
      for (int i = 0; i < 10; i++) begin
         wr_valid = (i == 4);
         wr_idx   = 2'd1;
         wr_data  = 4'h7;
         tick();
         checks++;
         if ({digit_en, blank, seg_nibble, frame_start} !== {exp_en, exp_blank, exp_seg, exp_fs}) begin
            errors++;
            $display("FAIL freeze_hold[%0d]: got en=%b blank=%b seg=%h fs=%b want en=%b blank=%b seg=%h fs=%b",
                     i, digit_en, blank, seg_nibble, frame_start, exp_en, exp_blank, exp_seg, exp_fs);
         end
      end
      idle_inputs();
      ena = 1'b1;
      for (int i = 0; i < 2 * SLOT; i++) begin
         tick();
         checks++;
         if ({digit_en, blank, seg_nibble, frame_start} !== {exp_en, exp_blank, exp_seg, exp_fs}) begin
            errors++;
            $display("FAIL freeze_resume[%0d]: got en=%b blank=%b seg=%h fs=%b want en=%b blank=%b seg=%h fs=%b",
                     i, digit_en, blank, seg_nibble, frame_start, exp_en, exp_blank, exp_seg, exp_fs);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 400; i++) begin
         ena      = ($urandom_range(0, 7) != 0);
         cnt_en   = 1'($urandom_range(0, 1));
         cnt_tick = 1'($urandom_range(0, 1));
         wr_valid = 1'($urandom_range(0, 1));
         wr_idx   = 2'($urandom_range(0, 3));
         wr_data  = 4'($urandom_range(0, 15));
         #1;
         checks++;
         if (wr_ready !== !cnt_en) begin
            errors++;
            $display("FAIL mixed_wr_ready[%0d]: got %b want %b", i, wr_ready, !cnt_en);
         end
         tick();
         checks++;
         if ({digit_en, blank, seg_nibble, frame_start, cnt_wrap} !== {exp_en, exp_blank, exp_seg, exp_fs, exp_wrap}) begin
            errors++;
            $display("FAIL mixed[%0d]: got en=%b blank=%b seg=%h fs=%b wrap=%b want en=%b blank=%b seg=%h fs=%b wrap=%b",
                     i, digit_en, blank, seg_nibble, frame_start, cnt_wrap, exp_en, exp_blank, exp_seg, exp_fs, exp_wrap);
         end
      end
      ena    = 1'b1;
      cnt_en = 1'b0;
      idle_inputs();
   endtask

   task automatic test_leading_zero();
      logic [3:0] seen_en = 4'b0000;
      logic [3:0] want;
      cnt_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1'b1;
         wr_idx   = 2'(i);
         wr_data  = (i == 0) ? 4'h5 : 4'h0;
         tick();
      end
      idle_inputs();
      for (int i = 0; i < PERIOD + SLOT; i++) begin
         tick();
         seen_en = seen_en | digit_en;
      end
`ifdef HEX_SCAN_LZ_BLANK_EN
      want = 4'b0001;
`else
      want = 4'b1111;
`endif
      checks++;
      if (seen_en !== want) begin
         errors++;
         $display("FAIL leading_zero: digits shown %b want %b", seen_en, want);
      end
   endtask

   task automatic test_async_reset();
      bit found = 1'b0;
      ena = 1'b1;
      for (int i = 0; i < PERIOD && !found; i++) begin
         tick();
         if (!exp_blank && ((kpos % PERIOD) / SLOT) == 2) found = 1'b1;
      end
      if (!found) begin
         errors++;
         checks++;
         $display("FAIL async_reset_timeout: SHOW of digit 2 not reached");
      end
      #2 rst = 1'b1;
      #1;
      model_reset();
      checks++;
      if ({digit_en, blank, seg_nibble, frame_start, cnt_wrap} !== {exp_en, exp_blank, exp_seg, exp_fs, exp_wrap}) begin
         errors++;
         $display("FAIL async_reset: got en=%b blank=%b seg=%h fs=%b wrap=%b, want reset values",
                  digit_en, blank, seg_nibble, frame_start, cnt_wrap);
      end
      #1 rst = 1'b0;
      for (int i = 0; i < PERIOD; i++) begin
         tick();
         checks++;
         if ({digit_en, blank, seg_nibble, frame_start} !== {exp_en, exp_blank, exp_seg, exp_fs}) begin
            errors++;
            $display("FAIL post_reset[%0d]: got en=%b blank=%b seg=%h fs=%b want en=%b blank=%b seg=%h fs=%b",
                     i, digit_en, blank, seg_nibble, frame_start, exp_en, exp_blank, exp_seg, exp_fs);
         end
         if (i == DC - 1) begin
            checks++;
            if (digit_en !== 4'b0001 || frame_start !== 1'b1) begin
               errors++;
               $display("FAIL restart_digit0: got en=%b fs=%b want en=0001 fs=1", digit_en, frame_start);
            end
         end
      end
   endtask

   initial begin
      ncycle = 0;
      test_reset();
      test_scan_timing();
      test_write();
      test_counter();
      test_freeze();
      test_back_to_back();
      test_leading_zero();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hex_scan_ctrl.md
HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

Interface
REQ-001 Parameter PRESCALE_W, default 8: width of the SHOW-phase timer; each SHOW phase lasts 2**PRESCALE_W clocks.
REQ-002 Parameter DEAD_CYCLES, default 2, legal 1..15: clocks of BLANK phase between digits.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ena  input  1  high = scan runs; low = scan timers and state frozen; counter and write port still active.
REQ-006 wr_valid  input  1  digit write request.
REQ-007 wr_idx  input  2  target digit, 0 = least significant.
REQ-008 wr_data  input  4  hex nibble to write.
REQ-009 wr_ready  output  1  write accepted when wr_valid && wr_ready at a clock edge.
REQ-010 cnt_en  input  1  high = the 4-digit counter owns the digit registers.
REQ-011 cnt_tick  input  1  single-cycle increment strobe, honoured only when cnt_en=1.
REQ-012 cnt_wrap  output  1  one-cycle pulse when the counter wraps FFFF->0000.
REQ-013 seg_nibble  output  4  nibble for the downstream 7-segment decoder.
REQ-014 digit_en  output  4  one-hot digit enable; all zero while blanked.
REQ-015 blank  output  1  high in BLANK state.
REQ-016 frame_start  output  1  one-cycle pulse on entry to SHOW for digit 0.

Function
REQ-017 Scheduler FSM states: BLANK, SHOW; index idx cycles 0,1,2,3,0 (wrap 3->0).
REQ-018 BLANK: digit_en=0, blank=1, seg_nibble=0; after DEAD_CYCLES enabled clocks -> SHOW.
REQ-019 SHOW: digit_en=1<<idx, blank=0, seg_nibble=digit[idx]; after 2**PRESCALE_W enabled clocks -> BLANK, idx advances.
REQ-020 frame_start asserts in the first SHOW cycle with idx=0 only.
REQ-021 All outputs registered; digit-register changes reach seg_nibble the cycle after the write/increment edge.
REQ-022 wr_ready = !cnt_en (combinational); accepted write updates digit[wr_idx] at that edge.
REQ-023 cnt_en=1 && cnt_tick=1: 16-bit value {digit3..digit0} increments by 1, modulo 2**16.
REQ-024 cnt_wrap pulses the cycle after the edge on which FFFF->0000 occurs.
REQ-025 Write and cnt_tick in same cycle cannot both act: cnt_en=1 blocks write; cnt_en=0 ignores tick.
REQ-026 ena=0 mid-phase: FSM, idx, phase timers hold; outputs hold their last values; resume exactly where stopped.
REQ-027 cnt_en toggling mid-scan does not disturb FSM timing.

Reset
REQ-028 On rst: state=BLANK, idx=0, timers=0, digits=0000, digit_en=0, blank=1, seg_nibble=0, cnt_wrap=0, frame_start=0.
REQ-029 Reset asserted mid-SHOW forces the reset values immediately (asynchronous); after release first SHOW is digit 0 after DEAD_CYCLES clocks.

Configuration
REQ-030 Macro HEX_SCAN_LZ_BLANK_EN defined: in SHOW for idx k>=1, digit_en=0 when digits k..3 are all zero (leading-zero suppression); digit 0 is always shown; FSM timing unchanged.
REQ-031 Macro undefined: every digit is shown in its SHOW phase regardless of value.

Structure
REQ-032 Package hex_scan_pkg holds: FSM state enum (BLANK, SHOW), NUM_DIGITS=4, NIBBLE_W=4, digit-index type.
REQ-033 One sub-module hex_scan_timer: loadable down-counter with enable providing the BLANK/SHOW phase-done strobe.
REQ-034 No segment decoding inside this block; decoder is downstream.

Verification
REQ-035 rst, then ena=1, PRESCALE_W=2, DEAD_CYCLES=2 -> digit_en sequence 0(2 clk),0001(4),0(2),0010(4)... frame_start every 24 clk.
REQ-036 cnt_en=0, write idx2=0xA -> next SHOW of idx2 shows seg_nibble=A, digit_en=0100.
REQ-037 cnt_en=1, preload via writes to FFFE first, then 2 ticks -> value 0000, one cnt_wrap pulse; wr_valid during cnt_en=1 -> wr_ready=0, digit unchanged.
REQ-038 ena=0 for 10 clk mid-SHOW of idx1 -> outputs frozen; resumes with remaining SHOW count.
REQ-039 HEX_SCAN_LZ_BLANK_EN, digits 0x0005 -> digit_en only 0001 active; undefined -> all four digits shown.
REQ-040 rst pulse mid-SHOW -> outputs at reset values same cycle; restart at idx 0.
